// File: rtl/cache_miss_arbiter.sv
// cache_miss_arbiter
// Shares one fill engine and memory port between the I-cache and the D-cache.
// Blocks are filled one at a time, and the D-cache wins when both caches miss
// in the same cycle. Returning words are steered into the data array of the
// cache being filled. After the last word, a one-cycle tag/valid write pulse
// is issued to that cache.

module cache_miss_arbiter #(
  parameter int WORDS_PER_BLOCK = 8,
  parameter int OFFSET_BITS     = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        icache_miss,
  input  logic [15:0] icache_miss_addr,
  input  logic        dcache_miss,
  input  logic [15:0] dcache_miss_addr,
  input  logic        memory_data_valid,
  input  logic [15:0] memory_data_out,
  output logic        miss_detected,
  output logic [15:0] miss_address,
  output logic        icache_data_we,
  output logic        dcache_data_we,
  output logic [$clog2(WORDS_PER_BLOCK)-1:0] fill_word,
  output logic [15:0] fill_data,
  output logic        icache_tag_we,
  output logic        dcache_tag_we,
  output logic        icache_stall,
  output logic        dcache_stall
);

  localparam int CW = $clog2(WORDS_PER_BLOCK);
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_BLOCK - 1);
  localparam logic [15:0] BASE_MASK = ~16'((1 << OFFSET_BITS) - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FILL_I = 3'd1;
  localparam logic [2:0] S_FILL_D = 3'd2;
  localparam logic [2:0] S_DONE_I = 3'd3;
  localparam logic [2:0] S_DONE_D = 3'd4;

  logic [2:0]    state;
  logic [CW-1:0] word_cnt;
  logic [15:0]   base_addr;
  logic          in_fill;

  // Arbitration, word counting and block completion. The D-cache is checked
  // first because its MEM-stage instruction is older than the IF-stage one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      word_cnt  <= '0;
      base_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (dcache_miss) begin
            base_addr <= dcache_miss_addr & BASE_MASK;
            state     <= S_FILL_D;
          end else if (icache_miss) begin
            base_addr <= icache_miss_addr & BASE_MASK;
            state     <= S_FILL_I;
          end
        end
        S_FILL_I, S_FILL_D: begin
          if (memory_data_valid) begin
            word_cnt <= word_cnt + CW'(1);
            if (word_cnt == LAST_WORD) begin
              state <= (state == S_FILL_I) ? S_DONE_I : S_DONE_D;
            end
          end
        end
        S_DONE_I, S_DONE_D: state <= S_IDLE;
        default:            state <= S_IDLE;
      endcase
    end
  end

  assign in_fill        = (state == S_FILL_I) || (state == S_FILL_D);
  assign miss_detected  = in_fill;
  assign miss_address   = in_fill ? base_addr : 16'h0000;
  assign icache_data_we = (state == S_FILL_I) && memory_data_valid;
  assign dcache_data_we = (state == S_FILL_D) && memory_data_valid;
  assign fill_word      = word_cnt;
  assign fill_data      = memory_data_out;
  assign icache_tag_we  = (state == S_DONE_I);
  assign dcache_tag_we  = (state == S_DONE_D);
  assign icache_stall   = icache_miss && (state != S_DONE_I);
  assign dcache_stall   = dcache_miss && (state != S_DONE_D);

endmodule
